// File: rtl/jtopl_slot_regs.sv
// OPL2-style operator and channel register file.
// The CPU writes an address and then data. The data is held in a one-entry pending buffer and is
// committed on the next slot-rate enable. Per-slot parameters are read out through registered
// outputs, indexed by the current {group, subslot} from the slot counter.
// Ports:
//   rst, clk, cen          - async active-high reset, clock, slot-rate enable
//   din, wr_addr, wr_data  - CPU bus: address-latch strobe and data strobe
//   group, subslot         - slot currently being processed
//   busy                   - a write is pending commit
//   am..wave               - operator parameters for the current slot
//   fnum..con              - channel parameters for the channel owning the current slot
module jtopl_slot_regs #(
  parameter int unsigned WAVE_EN = 0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       wr_addr,
  input  logic       wr_data,
  input  logic [1:0] group,
  input  logic [2:0] subslot,
  output logic       busy,
  output logic       am,
  output logic       vib,
  output logic       egt,
  output logic       ksr,
  output logic [3:0] mult,
  output logic [1:0] ksl,
  output logic [5:0] tl,
  output logic [3:0] ar,
  output logic [3:0] dr,
  output logic [3:0] sl,
  output logic [3:0] rr,
  output logic [1:0] wave,
  output logic [9:0] fnum,
  output logic [2:0] block,
  output logic       keyon,
  output logic [2:0] fb,
  output logic       con
);

  logic [7:0]  addr_q, addr_d;
  logic [15:0] pend_q, pend_d;  // {address, data}
  logic        busy_q, busy_d;

  // Operator storage, 18 entries, raw register images
  logic [17:0][7:0] r20_q, r20_d, r40_q, r40_d, r60_q, r60_d, r80_q, r80_d;
  logic [17:0][1:0] rwave_q, rwave_d;
  // Channel storage, 9 entries
  logic [8:0][7:0]  ra0_q, ra0_d;  // fnum[7:0]
  logic [8:0][5:0]  rb0_q, rb0_d;  // {keyon, block, fnum[9:8]}
  logic [8:0][3:0]  rc0_q, rc0_d;  // {fb, con}

  // Output registers
  logic [7:0] o20_q, o20_d, o40_q, o40_d, o60_q, o60_d, o80_q, o80_d;
  logic [1:0] owave_q, owave_d;
  logic [7:0] oa0_q, oa0_d;
  logic [5:0] ob0_q, ob0_d;
  logic [3:0] oc0_q, oc0_d;

  logic [7:0] wa, wd;
  logic       commit, wop_ok, wch_ok, rd_ok;
  logic [4:0] wop, rop;
  logic [3:0] wch, rch;
  logic [2:0] smod;

  always_comb begin
    wa     = pend_q[15:8];
    wd     = pend_q[7:0];
    commit = cen & busy_q;
    wop_ok = (wa[4:3] != 2'd3) && (wa[2:0] < 3'd6);
    wop    = {3'b0, wa[4:3]} * 5'd6 + {2'b0, wa[2:0]};
    wch_ok = wa[3:0] < 4'd9;
    wch    = wa[3:0];

    rd_ok  = (group != 2'd3) && (subslot < 3'd6);
    rop    = {3'b0, group} * 5'd6 + {2'b0, subslot};
    // Modulator and carrier of one channel share the channel entry
    smod   = (subslot >= 3'd3) ? subslot - 3'd3 : subslot;
    rch    = {2'b0, group} * 4'd3 + {1'b0, smod};
  end

  always_comb begin
    addr_d  = wr_addr ? din : addr_q;
    // A coincident wr_addr only affects later writes; capture uses the old latch
    pend_d  = wr_data ? {addr_q, din} : pend_q;
    busy_d  = wr_data | (busy_q & ~cen);

    r20_d   = r20_q;
    r40_d   = r40_q;
    r60_d   = r60_q;
    r80_d   = r80_q;
    rwave_d = rwave_q;
    ra0_d   = ra0_q;
    rb0_d   = rb0_q;
    rc0_d   = rc0_q;

    if (commit) begin
      case (wa[7:5])
        3'h1: if (wop_ok) r20_d[wop] = wd;
        3'h2: if (wop_ok) r40_d[wop] = wd;
        3'h3: if (wop_ok) r60_d[wop] = wd;
        3'h4: if (wop_ok) r80_d[wop] = wd;
        3'h7: if (wop_ok && WAVE_EN != 0) rwave_d[wop] = wd[1:0];
        default: ;
      endcase
      case (wa[7:4])
        4'hA: if (wch_ok) ra0_d[wch] = wd;
        4'hB: if (wch_ok) rb0_d[wch] = wd[5:0];
        4'hC: if (wch_ok) rc0_d[wch] = wd[3:0];
        default: ;
      endcase
    end

    o20_d   = o20_q;
    o40_d   = o40_q;
    o60_d   = o60_q;
    o80_d   = o80_q;
    owave_d = owave_q;
    oa0_d   = oa0_q;
    ob0_d   = ob0_q;
    oc0_d   = oc0_q;
    if (cen) begin
      // Reads use pre-commit state, so a same-edge write shows on the next visit
      if (rd_ok) begin
        o20_d   = r20_q[rop];
        o40_d   = r40_q[rop];
        o60_d   = r60_q[rop];
        o80_d   = r80_q[rop];
        owave_d = (WAVE_EN != 0) ? rwave_q[rop] : 2'd0;
        oa0_d   = ra0_q[rch];
        ob0_d   = rb0_q[rch];
        oc0_d   = rc0_q[rch];
      end else begin
        o20_d   = '0;
        o40_d   = '0;
        o60_d   = '0;
        o80_d   = '0;
        owave_d = '0;
        oa0_d   = '0;
        ob0_d   = '0;
        oc0_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      r20_q   <= '0;
      r40_q   <= '0;
      r60_q   <= '0;
      r80_q   <= '0;
      rwave_q <= '0;
      ra0_q   <= '0;
      rb0_q   <= '0;
      rc0_q   <= '0;
      o20_q   <= '0;
      o40_q   <= '0;
      o60_q   <= '0;
      o80_q   <= '0;
      owave_q <= '0;
      oa0_q   <= '0;
      ob0_q   <= '0;
      oc0_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      r20_q   <= r20_d;
      r40_q   <= r40_d;
      r60_q   <= r60_d;
      r80_q   <= r80_d;
      rwave_q <= rwave_d;
      ra0_q   <= ra0_d;
      rb0_q   <= rb0_d;
      rc0_q   <= rc0_d;
      o20_q   <= o20_d;
      o40_q   <= o40_d;
      o60_q   <= o60_d;
      o80_q   <= o80_d;
      owave_q <= owave_d;
      oa0_q   <= oa0_d;
      ob0_q   <= ob0_d;
      oc0_q   <= oc0_d;
    end
  end

  assign busy  = busy_q;
  assign am    = o20_q[7];
  assign vib   = o20_q[6];
  assign egt   = o20_q[5];
  assign ksr   = o20_q[4];
  assign mult  = o20_q[3:0];
  assign ksl   = o40_q[7:6];
  assign tl    = o40_q[5:0];
  assign ar    = o60_q[7:4];
  assign dr    = o60_q[3:0];
  assign sl    = o80_q[7:4];
  assign rr    = o80_q[3:0];
  assign wave  = owave_q;
  assign fnum  = {ob0_q[1:0], oa0_q};
  assign block = ob0_q[4:2];
  assign keyon = ob0_q[5];
  assign fb    = oc0_q[3:1];
  assign con   = oc0_q[0];

endmodule

// File: tb/tb_jtopl_slot_regs.sv
// Directed bench for jtopl_slot_regs with hand-computed expected values.
module tb_jtopl_slot_regs;

  logic       rst, clk, cen;
  logic [7:0] din;
  logic       wr_addr, wr_data;
  logic [1:0] group;
  logic [2:0] subslot;
  logic       busy, am, vib, egt, ksr, keyon, con;
  logic [3:0] mult, ar, dr, sl, rr;
  logic [1:0] ksl, wave;
  logic [5:0] tl;
  logic [9:0] fnum;
  logic [2:0] block, fb;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  jtopl_slot_regs dut (
    .rst     (rst),
    .clk     (clk),
    .cen     (cen),
    .din     (din),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .group   (group),
    .subslot (subslot),
    .busy    (busy),
    .am      (am),
    .vib     (vib),
    .egt     (egt),
    .ksr     (ksr),
    .mult    (mult),
    .ksl     (ksl),
    .tl      (tl),
    .ar      (ar),
    .dr      (dr),
    .sl      (sl),
    .rr      (rr),
    .wave    (wave),
    .fnum    (fnum),
    .block   (block),
    .keyon   (keyon),
    .fb      (fb),
    .con     (con)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    din = a; wr_addr = 1'b1; tick(); wr_addr = 1'b0;
    din = d; wr_data = 1'b1; tick(); wr_data = 1'b0;
  endtask

  task automatic step(input logic [1:0] g, input logic [2:0] s);
    group = g; subslot = s; cen = 1'b1; tick(); cen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; din = '0; wr_addr = 1'b0; wr_data = 1'b0;
    group = '0; subslot = '0;
    tick(); tick();
    check("reset busy", 32'(busy), 0);
    check("reset fnum", 32'(fnum), 0);
    check("reset tl", 32'(tl), 0);
    rst = 1'b0;
    tick();

    // 0x23 = 0x21 held pending while cen is low
    wr(8'h23, 8'h21);
    check("pend busy", 32'(busy), 1);
    tick(); tick();
    check("pend busy hold", 32'(busy), 1);
    step(0, 0);
    check("commit busy", 32'(busy), 0);
    check("s0 mult", 32'(mult), 0);
    step(0, 3);
    check("s3 op20", 32'({am, vib, egt, ksr, mult}), 32'h21);

    // Unmapped operator offset and non-register address
    wr(8'h46, 8'hAA);
    step(2, 5);
    check("0x46 busy", 32'(busy), 0);
    wr(8'h1E, 8'hBB);
    step(2, 5);
    check("0x1E busy", 32'(busy), 0);
    for (int g = 0; g < 3; g++)
      for (int s = 0; s < 6; s++) begin
        step(2'(g), 3'(s));
        check($sformatf("tl g%0d s%0d", g, s), 32'(tl), 0);
      end

    // Channel registers
    wr(8'hA4, 8'h44);
    step(2, 5);
    wr(8'hB4, 8'h32);
    step(2, 5);
    step(1, 1);
    check("g1s1 ch", 32'({fnum, block, keyon}), 32'({10'h244, 3'd4, 1'b1}));
    step(1, 4);
    check("g1s4 ch", 32'({fnum, block, keyon}), 32'({10'h244, 3'd4, 1'b1}));
    step(0, 1);
    check("g0s1 fnum", 32'(fnum), 0);
    step(2, 1);
    check("g2s1 fnum", 32'(fnum), 0);
    step(1, 6);
    check("invalid subslot", 32'({fnum, keyon, tl, mult}), 0);

    // Last write wins while pending
    wr(8'h40, 8'h3F);
    wr(8'h40, 8'h05);
    step(2, 5);
    step(0, 0);
    check("last wins tl", 32'(tl), 5);
    check("last wins ksl", 32'(ksl), 0);

    // Read-before-write on the same slot
    wr(8'h6A, 8'hF3);
    step(1, 2);
    check("rbw old", 32'({ar, dr}), 0);
    check("rbw busy", 32'(busy), 0);
    step(1, 2);
    check("rbw new", 32'({ar, dr}), 32'hF3);
    group = 2'd0; subslot = 3'd0; tick();
    check("hold ar", 32'(ar), 15);

    // New write coincides with the commit edge
    din = 8'h20; wr_addr = 1'b1; tick(); wr_addr = 1'b0;
    din = 8'h01; wr_data = 1'b1; tick();
    din = 8'h0F; group = 2'd2; subslot = 3'd5; cen = 1'b1; tick();
    wr_data = 1'b0; cen = 1'b0;
    check("coinc busy", 32'(busy), 1);
    step(0, 0);
    check("coinc old mult", 32'(mult), 1);
    check("coinc busy clr", 32'(busy), 0);
    step(0, 0);
    check("coinc new mult", 32'(mult), 15);

    // Wave select disabled by default
    wr(8'hE0, 8'h03);
    step(2, 5);
    step(0, 0);
    check("wave disabled", 32'(wave), 0);

    // Reset while a write is pending
    wr(8'h80, 8'hFF);
    check("pre-rst busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst mult", 32'(mult), 0);
    tick();
    rst = 1'b0;
    step(2, 5);
    step(0, 0);
    check("post-rst slrr", 32'({sl, rr}), 0);
    check("post-rst mult", 32'(mult), 0);
    step(1, 2);
    check("post-rst ar", 32'(ar), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
